// File: rtl/digit_sprite_renderer_if.sv
// -----------------------------------------------------------------------------
// digit_sprite_renderer_if
// Groups every non-clock signal of the digit sprite renderer into one bundle.
//   frame_start              one-cycle pulse at the start of vertical blank
//   pos_x_in / pos_y_in      requested sprite origin (left column / top row)
//   show_in / blink_en       requested enable and blink mode
//   pix_valid_in, DrawX, DrawY, bg_color   incoming scan pixel
//   rom_addr / rom_data      address to, and registered data from, the ROM
//   pixel_color / pix_valid_out            composited output pixel
// The master modport is the driving side (scan logic, ROM, next layer);
// the slave modport is the renderer itself.
// -----------------------------------------------------------------------------
interface digit_sprite_renderer_if;
    logic        frame_start;
    logic [9:0]  pos_x_in;
    logic [9:0]  pos_y_in;
    logic        show_in;
    logic        blink_en;
    logic        pix_valid_in;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [23:0] bg_color;
    logic [18:0] rom_addr;
    logic [23:0] rom_data;
    logic [23:0] pixel_color;
    logic        pix_valid_out;

    modport master (
        output frame_start, pos_x_in, pos_y_in, show_in, blink_en,
        output pix_valid_in, DrawX, DrawY, bg_color,
        input  rom_addr,
        output rom_data,
        input  pixel_color, pix_valid_out
    );

    modport slave (
        input  frame_start, pos_x_in, pos_y_in, show_in, blink_en,
        input  pix_valid_in, DrawX, DrawY, bg_color,
        output rom_addr,
        input  rom_data,
        output pixel_color, pix_valid_out
    );
endinterface

// File: rtl/digit_sprite_renderer.sv
// -----------------------------------------------------------------------------
// digit_sprite_renderer
// Pixel pipeline stage that overlays a SPRITE_W x SPRITE_H digit sprite, read
// from a ROM with one cycle of read latency, on top of a lower-layer colour.
// Ports:
//   Clk    pixel clock, all state on the rising edge
//   Reset  asynchronous active-high reset
//   bus    digit_sprite_renderer_if.slave (origin/enable/blink controls,
//          scan pixel in, ROM address/data, composited pixel out)
// Origin, enable and blink mode are sampled only on frame_start so the sprite
// never tears mid-frame. Output latency is two cycles from the scan inputs.
// -----------------------------------------------------------------------------
module digit_sprite_renderer #(
    parameter int          SPRITE_W     = 32,
    parameter int          SPRITE_H     = 32,
    parameter logic [23:0] KEY_COLOR    = 24'hFFFFFF,
    parameter int          BLINK_FRAMES = 30
) (
    input logic                     Clk,
    input logic                     Reset,
    digit_sprite_renderer_if.slave  bus
);

    localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);

    logic [9:0]  x0_q;
    logic [9:0]  y0_q;
    logic        shownReq_q;
    logic        blinkMode_q;
    logic [5:0]  blinkCnt_q;
    logic        blinkPhase_q;

    logic        hitDly_q;
    logic        validDly_q;
    logic [23:0] bgDly_q;

    logic [23:0] pixelColor_q;
    logic [23:0] pixelColor_d;
    logic        pixValidOut_q;

    logic        visible;
    logic        hit;
    logic [10:0] xEnd;
    logic [10:0] yEnd;
    logic [9:0]  dx;
    logic [9:0]  dy;

    // Per-frame shadow registers and blink counter. Blink decisions use the
    // blink_en value being loaded this frame, not the previous one.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x0_q         <= '0;
            y0_q         <= '0;
            shownReq_q   <= 1'b0;
            blinkMode_q  <= 1'b0;
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b1;
        end else if (bus.frame_start) begin
            x0_q        <= bus.pos_x_in;
            y0_q        <= bus.pos_y_in;
            shownReq_q  <= bus.show_in;
            blinkMode_q <= bus.blink_en;
            if (bus.blink_en) begin
                if (blinkCnt_q == BLINK_LAST) begin
                    blinkCnt_q   <= '0;
                    blinkPhase_q <= ~blinkPhase_q;
                end else begin
                    blinkCnt_q <= blinkCnt_q + 6'd1;
                end
            end else begin
                blinkCnt_q   <= '0;
                blinkPhase_q <= 1'b1;
            end
        end
    end

    // Hit test in 11 bits so a sprite hanging off the right/bottom edge does
    // not wrap its far boundary back to small coordinates.
    always_comb begin
        visible = shownReq_q & (blinkPhase_q | ~blinkMode_q);
        xEnd    = {1'b0, x0_q} + 11'(SPRITE_W);
        yEnd    = {1'b0, y0_q} + 11'(SPRITE_H);
        hit     = visible & bus.pix_valid_in
                & ({1'b0, bus.DrawX} >= {1'b0, x0_q}) & ({1'b0, bus.DrawX} < xEnd)
                & ({1'b0, bus.DrawY} >= {1'b0, y0_q}) & ({1'b0, bus.DrawY} < yEnd);
        dx      = bus.DrawX - x0_q;
        dy      = bus.DrawY - y0_q;
    end

    assign bus.rom_addr = hit ? (19'(dy) * 19'(SPRITE_W) + 19'(dx)) : '0;

    // Stage 1 delays the side-band data to line up with the ROM's registered
    // output.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hitDly_q   <= 1'b0;
            validDly_q <= 1'b0;
            bgDly_q    <= '0;
        end else begin
            hitDly_q   <= hit;
            validDly_q <= bus.pix_valid_in;
            bgDly_q    <= bus.bg_color;
        end
    end

    // Key-colour pixels of the sprite fall through to the lower layer; the
    // output is forced to black when no valid pixel is in this slot.
    always_comb begin
        pixelColor_d = '0;
        if (validDly_q) begin
            if (hitDly_q && (bus.rom_data != KEY_COLOR)) begin
                pixelColor_d = bus.rom_data;
            end else begin
                pixelColor_d = bgDly_q;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pixelColor_q  <= '0;
            pixValidOut_q <= 1'b0;
        end else begin
            pixelColor_q  <= pixelColor_d;
            pixValidOut_q <= validDly_q;
        end
    end

    assign bus.pixel_color   = pixelColor_q;
    assign bus.pix_valid_out = pixValidOut_q;

endmodule

// File: doc/digit_sprite_renderer.md
# digit_sprite_renderer

Pixel-pipeline stage between the VGA scan counters and a 32x32 digit sprite ROM such as `frameRAM_seven`. It latches a per-frame sprite origin, turns the current scan position into a ROM `read_address`, and delays the in-sprite flag and background colour to line up with the ROM's one-cycle registered `data_Out`. It then composites the sprite over the lower-layer colour, with colour-key transparency and optional frame-counted blinking, and hands the result to the next layer or the VGA output register.

## Interface
- SPRITE_W, 32, sprite width in pixels (power of two).
- SPRITE_H, 32, sprite height in pixels.
- KEY_COLOR, 24'hFFFFFF, ROM colour treated as transparent.
- BLINK_FRAMES, 30, frames per blink half-period (1..63).

Ports:
- Clk  in  1  pixel clock, all logic on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- pos_x_in  in  10  requested sprite origin X (left column).
- pos_y_in  in  10  requested sprite origin Y (top row).
- show_in  in  1  requested sprite enable.
- blink_en  in  1  enables blinking (sampled on frame_start).
- pix_valid_in  in  1  DrawX/DrawY/bg_color valid this cycle.
- DrawX  in  10  current scan column.
- DrawY  in  10  current scan row.
- bg_color  in  24  lower-layer colour for this pixel.
- rom_addr  out  19  combinational address to the ROM `read_address`.
- rom_data  in  24  ROM `data_Out`, valid one cycle after rom_addr.
- pixel_color  out  24  composited colour.
- pix_valid_out  out  1  pixel_color valid.

## Operation
- Shadow registers x0, y0, shown_req, blink_mode load from pos_x_in, pos_y_in, show_in, and blink_en only on a cycle with frame_start=1. Mid-frame input changes do not move the sprite. Reset value of all shadow registers is 0.
- Blink counter: 6-bit frame counter plus a phase bit.
  - On frame_start, with the new blink_mode=1: if the counter equals BLINK_FRAMES-1, clear it and toggle phase; otherwise increment.
  - With blink_mode=0: counter cleared, phase forced to 1.
  - Reset: counter 0, phase 1.
- visible = shown_req & (phase | ~blink_mode).
- Hit test, done in 11-bit arithmetic so x0+SPRITE_W past 1023 does not wrap: hit = visible & pix_valid_in & DrawX ≥ x0 & DrawX < x0+SPRITE_W & DrawY ≥ y0 & DrawY < y0+SPRITE_H.
- rom_addr = hit ? (DrawY−y0)·SPRITE_W + (DrawX−x0) : 0, zero-extended to 19 bits. Range 0..SPRITE_W·SPRITE_H−1.
- Stage 1 (registered): hit_d, valid_d, bg_d ← hit, pix_valid_in, bg_color. These are aligned with rom_data.
- Stage 2 (registered): pix_valid_out ← valid_d.
  - pixel_color ← (hit_d & rom_data ≠ KEY_COLOR) ? rom_data : bg_d when valid_d=1.
  - pixel_color ← 0 when valid_d=0.

## Timing
- Latency is 2 cycles from DrawX/DrawY/bg_color/pix_valid_in to pixel_color/pix_valid_out, with one pixel per cycle and no stalls.
- rom_addr has zero latency (combinational from DrawX/DrawY and the shadow registers).
- frame_start in cycle N: the new origin, enable, and blink state apply to pixels presented from cycle N+1. Pixels already in the pipe complete with the old values.
- frame_start and pix_valid_in both high in the same cycle: that pixel uses the old shadow values.
- Reset asserted at any time: pixel_color=0, pix_valid_out=0, hit_d=0, valid_d=0, bg_d=0, and shadow and blink state at reset values, all within the same cycle. After Reset deasserts, the first valid output appears 2 cycles after the first pix_valid_in.
- Right and bottom edges: DrawX = x0+SPRITE_W−1 is inside the sprite; DrawX = x0+SPRITE_W is outside, including when x0 ≥ 992.

## Test plan
- Reset mid-stream: drive valid pixels, assert Reset for 1 cycle → pixel_color=0 and pix_valid_out=0 the same cycle; first output 2 cycles after pix_valid_in resumes.
- Origin (100,50) loaded by frame_start, scan DrawY=50, DrawX=99..132 → rom_addr 0 at DrawX=99 (miss), 0..31 for DrawX=100..131, 0 at 132. pixel_color is rom_data for hits and bg_color for misses, 2 cycles later.
- Same origin, DrawX=110, DrawY=53 → rom_addr=106. ROM returns 24'h000000 → pixel_color=000000. ROM returns FFFFFF → pixel_color=bg_color (e.g. 24'h123456).
- Edge wrap: x0=1000, DrawX=1023 → hit with addr offset 23. DrawX=8 on the same row → miss.
- Change pos_x_in mid-frame without frame_start → sprite position unchanged until the next frame_start pulse.
- blink_en=1, show_in=1, BLINK_FRAMES=2 → sprite alternates visible/hidden every 2 frame_start pulses. blink_en=0 → always visible.
